// File: rtl/expr_seq_verify_if.sv
// rtl/expr_seq_verify_if.sv - character stream in, verdict/report signals out
// Ports (master = character source and report consumer, slave = checker):
//   ascii_char, char_valid                   : one character per char_valid strobe
//   sequence_valid, output_strobe, last_op   : verdict of the last evaluated frame
//   ok_cnt, bad_cnt                          : saturating frame counters
interface expr_seq_verify_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       ascii_char;
    logic             char_valid;
    logic             sequence_valid;
    logic             output_strobe;
    logic [1:0]       last_op;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] bad_cnt;

    modport master (
        output ascii_char, char_valid,
        input  sequence_valid, output_strobe, last_op, ok_cnt, bad_cnt
    );

    modport slave (
        input  ascii_char, char_valid,
        output sequence_valid, output_strobe, last_op, ok_cnt, bad_cnt
    );
endinterface

// File: rtl/expr_seq_verify.sv
// rtl/expr_seq_verify.sv - framed ASCII expression checker (NUL, A digits, op, B digits, NUL)
// Ports:
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of expr_seq_verify_if (character stream in, verdict/counters out)
module expr_seq_verify #(
    parameter int         A_MIN        = 3,
    parameter int         A_MAX        = 3,
    parameter int         B_MIN        = 3,
    parameter int         B_MAX        = 3,
    parameter logic [3:0] OP_MASK      = 4'b0001,
    parameter int         freq         = 200,
    parameter int         UART_TX_baud = 20,
    parameter int         CNT_W        = 8
) (
    input logic              clk,
    input logic              rst_n,
    expr_seq_verify_if.slave bus
);
    localparam int STROBE_LEN = freq / UART_TX_baud;
    localparam int TMR_W      = (STROBE_LEN < 1) ? 1 : $clog2(STROBE_LEN + 1);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STROBE_LEN);
    localparam logic [3:0]       A_MIN_C  = 4'(A_MIN);
    localparam logic [3:0]       A_MAX_C  = 4'(A_MAX);
    localparam logic [3:0]       B_MIN_C  = 4'(B_MIN);
    localparam logic [3:0]       B_MAX_C  = 4'(B_MAX);

    if (A_MIN < 1 || A_MIN > A_MAX || A_MAX > 15 ||
        B_MIN < 1 || B_MIN > B_MAX || B_MAX > 15 || STROBE_LEN < 1) begin : g_param_err
        $error("expr_seq_verify: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A    = 2'd1,
        ST_B    = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       a_cnt, a_cnt_nx;
    logic [3:0]       b_cnt, b_cnt_nx;
    logic [1:0]       op_lat, op_lat_nx;
    logic             seq_valid, seq_valid_nx;
    logic [1:0]       last_op, last_op_nx;
    logic [CNT_W-1:0] ok_cnt, ok_cnt_nx;
    logic [CNT_W-1:0] bad_cnt, bad_cnt_nx;
    logic [TMR_W-1:0] timer, timer_nx;

    logic       is_nul;
    logic       is_digit;
    logic       is_op;
    logic [1:0] op_code;
    logic       eval;
    logic       verdict;

    // Disabled operators simply never raise is_op, so they fall into OTHER.
    always_comb begin
        is_nul   = (bus.ascii_char == 8'h00);
        is_digit = (bus.ascii_char >= 8'h30) && (bus.ascii_char <= 8'h39);
        op_code  = 2'd0;
        is_op    = 1'b0;
        case (bus.ascii_char)
            8'h2B: begin op_code = 2'd0; is_op = OP_MASK[0]; end
            8'h2D: begin op_code = 2'd1; is_op = OP_MASK[1]; end
            8'h2A: begin op_code = 2'd2; is_op = OP_MASK[2]; end
            8'h2F: begin op_code = 2'd3; is_op = OP_MASK[3]; end
            default: ;
        endcase
    end

    always_comb begin
        state_nx     = state;
        a_cnt_nx     = a_cnt;
        b_cnt_nx     = b_cnt;
        op_lat_nx    = op_lat;
        eval         = 1'b0;
        verdict      = 1'b0;
        seq_valid_nx = seq_valid;
        last_op_nx   = last_op;
        ok_cnt_nx    = ok_cnt;
        bad_cnt_nx   = bad_cnt;

        if (bus.char_valid) begin
            case (state)
                ST_IDLE: begin
                    // Unsynchronised: wait for the first NUL to open a frame.
                    if (is_nul) begin
                        state_nx = ST_A;
                        a_cnt_nx = 4'd0;
                        b_cnt_nx = 4'd0;
                    end
                end
                ST_A: begin
                    if (is_digit) begin
                        if (a_cnt == A_MAX_C) state_nx = ST_ERR;
                        else                  a_cnt_nx = a_cnt + 4'd1;
                    end else if (is_op) begin
                        if (a_cnt >= A_MIN_C) begin
                            state_nx  = ST_B;
                            op_lat_nx = op_code;
                        end else begin
                            state_nx = ST_ERR;
                        end
                    end else if (is_nul) begin
                        // An empty frame (NUL NUL) is not evaluated.
                        if (a_cnt != 4'd0) eval = 1'b1;
                    end else begin
                        state_nx = ST_ERR;
                    end
                end
                ST_B: begin
                    if (is_digit) begin
                        if (b_cnt == B_MAX_C) state_nx = ST_ERR;
                        else                  b_cnt_nx = b_cnt + 4'd1;
                    end else if (is_nul) begin
                        eval    = 1'b1;
                        verdict = (b_cnt >= B_MIN_C);
                    end else begin
                        state_nx = ST_ERR;
                    end
                end
                default: begin
                    if (is_nul) eval = 1'b1;
                end
            endcase
        end

        // The closing NUL also opens the next frame.
        if (eval) begin
            state_nx     = ST_A;
            a_cnt_nx     = 4'd0;
            b_cnt_nx     = 4'd0;
            seq_valid_nx = verdict;
            if (verdict) begin
                last_op_nx = op_lat;
                if (ok_cnt != {CNT_W{1'b1}}) ok_cnt_nx = ok_cnt + CNT_W'(1);
            end else begin
                if (bad_cnt != {CNT_W{1'b1}}) bad_cnt_nx = bad_cnt + CNT_W'(1);
            end
        end

        // A new evaluation reloads the timer even while the strobe is active.
        if (eval)                   timer_nx = TMR_LOAD;
        else if (timer != '0)       timer_nx = timer - TMR_W'(1);
        else                        timer_nx = timer;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_cnt     <= 4'd0;
            b_cnt     <= 4'd0;
            op_lat    <= 2'd0;
            seq_valid <= 1'b0;
            last_op   <= 2'd0;
            ok_cnt    <= '0;
            bad_cnt   <= '0;
            timer     <= '0;
        end else begin
            state     <= state_nx;
            a_cnt     <= a_cnt_nx;
            b_cnt     <= b_cnt_nx;
            op_lat    <= op_lat_nx;
            seq_valid <= seq_valid_nx;
            last_op   <= last_op_nx;
            ok_cnt    <= ok_cnt_nx;
            bad_cnt   <= bad_cnt_nx;
            timer     <= timer_nx;
        end
    end

    assign bus.sequence_valid = seq_valid;
    assign bus.output_strobe  = (timer != '0);
    assign bus.last_op        = last_op;
    assign bus.ok_cnt         = ok_cnt;
    assign bus.bad_cnt        = bad_cnt;
endmodule

// File: tb/tb_expr_seq_verify.sv
// tb/tb_expr_seq_verify.sv - three parameter sets of expr_seq_verify against a frame-level model
module tb_expr_seq_verify;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ch = 8'h00;
    logic       vld = 1'b0;

    always #5 clk = ~clk;

    expr_seq_verify_if #(.CNT_W(8)) if0 ();
    expr_seq_verify_if #(.CNT_W(8)) if1 ();
    expr_seq_verify_if #(.CNT_W(2)) if2 ();

    assign if0.ascii_char = ch;
    assign if0.char_valid = vld;
    assign if1.ascii_char = ch;
    assign if1.char_valid = vld;
    assign if2.ascii_char = ch;
    assign if2.char_valid = vld;

    // 0: defaults; 1: all operators, 1..4 digits, 3-cycle strobe; 2: 1..3 digits, 1-cycle strobe, 2-bit counters
    expr_seq_verify u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    expr_seq_verify #(.A_MIN(1), .A_MAX(4), .B_MIN(1), .B_MAX(4), .OP_MASK(4'b1111),
                      .freq(60), .UART_TX_baud(20), .CNT_W(8))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    expr_seq_verify #(.A_MIN(1), .A_MAX(3), .B_MIN(1), .B_MAX(3), .OP_MASK(4'b0001),
                      .freq(20), .UART_TX_baud(20), .CNT_W(2))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic       d_valid [3];
    logic       d_strobe[3];
    logic [1:0] d_op    [3];
    logic [7:0] d_ok    [3];
    logic [7:0] d_bad   [3];

    assign d_valid[0] = if0.sequence_valid;
    assign d_valid[1] = if1.sequence_valid;
    assign d_valid[2] = if2.sequence_valid;
    assign d_strobe[0] = if0.output_strobe;
    assign d_strobe[1] = if1.output_strobe;
    assign d_strobe[2] = if2.output_strobe;
    assign d_op[0] = if0.last_op;
    assign d_op[1] = if1.last_op;
    assign d_op[2] = if2.last_op;
    assign d_ok[0] = if0.ok_cnt;
    assign d_ok[1] = if1.ok_cnt;
    assign d_ok[2] = {6'b0, if2.ok_cnt};
    assign d_bad[0] = if0.bad_cnt;
    assign d_bad[1] = if1.bad_cnt;
    assign d_bad[2] = {6'b0, if2.bad_cnt};

    function automatic int p_amin(input int k); return (k == 0) ? 3 : 1; endfunction
    function automatic int p_amax(input int k); return (k == 1) ? 4 : 3; endfunction
    function automatic int p_mask(input int k); return (k == 1) ? 15 : 1; endfunction
    function automatic int p_len (input int k); return (k == 0) ? 10 : ((k == 1) ? 3 : 1); endfunction
    function automatic int p_sat (input int k); return (k == 2) ? 3 : 255; endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Frame-level model: collect the characters between NULs, then parse the whole frame.
    bit           synced;
    byte unsigned fbuf[$];
    int           m_valid[3], m_op[3], m_ok[3], m_bad[3], m_tmr[3];
    bit           j_ok;
    int           j_op;

    function automatic bit is_dig(input byte unsigned c);
        return (c >= 8'd48) && (c <= 8'd57);
    endfunction

    function automatic int op_index(input byte unsigned c);
        case (c)
            8'd43:   return 0;
            8'd45:   return 1;
            8'd42:   return 2;
            8'd47:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic judge(input int k, output bit ok, output int op);
        int i  = 0;
        int la = 0;
        int lb = 0;
        ok = 1'b0;
        op = 0;
        while (i < fbuf.size() && is_dig(fbuf[i])) begin la++; i++; end
        if (i >= fbuf.size()) return;
        op = op_index(fbuf[i]);
        if (op < 0 || ((p_mask(k) >> op) & 1) == 0) return;
        i++;
        while (i < fbuf.size() && is_dig(fbuf[i])) begin lb++; i++; end
        ok = (i == fbuf.size()) && la >= p_amin(k) && la <= p_amax(k)
                                && lb >= p_amin(k) && lb <= p_amax(k);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced = 1'b0;
            fbuf.delete();
            for (int k = 0; k < 3; k++) begin
                m_valid[k] = 0; m_op[k] = 0; m_ok[k] = 0; m_bad[k] = 0; m_tmr[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++)
                if (m_tmr[k] > 0) m_tmr[k]--;
            if (vld) begin
                if (ch == 8'h00) begin
                    if (synced && fbuf.size() > 0) begin
                        for (int k = 0; k < 3; k++) begin
                            judge(k, j_ok, j_op);
                            m_valid[k] = j_ok;
                            if (j_ok) begin
                                m_op[k] = j_op;
                                if (m_ok[k] < p_sat(k)) m_ok[k]++;
                            end else if (m_bad[k] < p_sat(k)) begin
                                m_bad[k]++;
                            end
                            m_tmr[k] = p_len(k);
                        end
                    end
                    synced = 1'b1;
                    fbuf.delete();
                end else if (synced) begin
                    fbuf.push_back(ch);
                end
            end
        end
    end

    int strobe_hi0 = 0;
    int drops = 0;
    bit watch = 1'b0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("sequence_valid", k, 32'(d_valid[k]), m_valid[k]);
            chk("output_strobe",  k, 32'(d_strobe[k]), (m_tmr[k] != 0) ? 1 : 0);
            chk("last_op",        k, 32'(d_op[k]), m_op[k]);
            chk("ok_cnt",         k, 32'(d_ok[k]), m_ok[k]);
            chk("bad_cnt",        k, 32'(d_bad[k]), m_bad[k]);
        end
        if (d_strobe[0] === 1'b1) strobe_hi0++;
        if (watch && d_strobe[0] !== 1'b1) drops++;
    end

    // All drive tasks are entered at a negedge and return at a negedge.
    task automatic send(input byte unsigned c, input int gap);
        ch  = c;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic assert_reset();
        vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        strobe_hi0 = 0;
    endtask

    task automatic full_reset();
        assert_reset();
        release_reset();
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned fr[$];
        int           la, lb, pos;
        idle(2);
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", k, 32'(d_valid[k]), 0);
            chk("reset_ok",    k, 32'(d_ok[k]), 0);
        end
        release_reset();

        // Valid default frame at 10-cycle spacing
        send(8'h00, 9); send_str("123+456", 9); send(8'h00, 0);
        idle(20);
        chk("s1_strobe_len", 0, 32'(strobe_hi0), 10);
        chk("s1_valid", 0, 32'(d_valid[0]), 1);
        chk("s1_op",    0, 32'(d_op[0]), 0);
        chk("s1_ok",    0, 32'(d_ok[0]), 1);
        chk("s1_bad",   0, 32'(d_bad[0]), 0);

        // Short operand A: ERR at '+', only the closing NUL strobes
        full_reset();
        send(8'h00, 9); send_str("12+3456", 9); send(8'h00, 0);
        idle(20);
        chk("s2_strobe_len", 0, 32'(strobe_hi0), 10);
        chk("s2_valid", 0, 32'(d_valid[0]), 0);
        chk("s2_bad",   0, 32'(d_bad[0]), 1);

        // Operator masks and wider operand ranges
        full_reset();
        send(8'h00, 1); send_str("123-456", 1); send(8'h00, 1);
        chk("s3_minus_valid", 0, 32'(d_valid[0]), 0);
        chk("s3_minus_valid", 1, 32'(d_valid[1]), 1);
        chk("s3_minus_op",    1, 32'(d_op[1]), 1);
        send_str("7*8901", 1); send(8'h00, 1);
        chk("s3_mul_valid", 1, 32'(d_valid[1]), 1);
        chk("s3_mul_op",    1, 32'(d_op[1]), 2);
        send_str("12345/6", 1); send(8'h00, 1);
        chk("s3_div_valid", 1, 32'(d_valid[1]), 0);
        chk("s3_div_op",    1, 32'(d_op[1]), 2);
        chk("s3_div_bad",   1, 32'(d_bad[1]), 1);

        // Back-to-back frames with an empty NUL-NUL pair; strobe reloads without a gap
        full_reset();
        send(8'h00, 0); send_str("123+456", 0); send(8'h00, 0);
        watch = 1'b1;
        send(8'h00, 0); send_str("999+000", 0); send(8'h00, 0);
        watch = 1'b0;
        idle(20);
        chk("s4_drops",  0, 32'(drops), 0);
        chk("s4_strobe", 0, 32'(strobe_hi0), 19);
        chk("s4_ok",     0, 32'(d_ok[0]), 2);
        chk("s4_bad",    0, 32'(d_bad[0]), 0);

        // No leading NUL: ignored
        full_reset();
        send_str("123+456", 0);
        idle(15);
        chk("s5_no_strobe", 0, 32'(strobe_hi0), 0);
        chk("s5_no_ok",     0, 32'(d_ok[0]), 0);
        send(8'h00, 0); send_str("1+2", 0); send(8'h00, 0);
        chk("s5_valid", 2, 32'(d_valid[2]), 1);
        chk("s5_ok",    2, 32'(d_ok[2]), 1);

        // Reset mid-frame, then mid-strobe
        full_reset();
        send(8'h00, 0); send_str("12", 0);
        full_reset();
        send_str("3+456", 0); send(8'h00, 0);
        idle(3);
        chk("s6_no_eval_ok",  2, 32'(d_ok[2]), 0);
        chk("s6_no_eval_bad", 2, 32'(d_bad[2]), 0);
        chk("s6_no_strobe",   0, 32'(strobe_hi0), 0);
        send_str("123+456", 0); send(8'h00, 2);
        chk("s6_strobe_on", 0, 32'(d_strobe[0]), 1);
        assert_reset();
        chk("s6_rst_strobe", 0, 32'(d_strobe[0]), 0);
        chk("s6_rst_valid",  0, 32'(d_valid[0]), 0);
        chk("s6_rst_ok",     0, 32'(d_ok[0]), 0);
        release_reset();

        // Saturation of the 2-bit counter
        send(8'h00, 0);
        repeat (5) begin send_str("1+2", 0); send(8'h00, 0); end
        idle(2);
        chk("s7_sat_ok",  2, 32'(d_ok[2]), 3);
        chk("s7_sat_bad", 2, 32'(d_bad[2]), 0);
        chk("s7_bad0",    0, 32'(d_bad[0]), 5);

        // Random frames with junk, empty frames and occasional resets
        full_reset();
        repeat (400) begin
            if ($urandom_range(0, 59) == 0) full_reset();
            fr.delete();
            la = $urandom_range(0, 5);
            lb = $urandom_range(0, 5);
            repeat (la) fr.push_back(8'(48 + $urandom_range(0, 9)));
            case ($urandom_range(0, 3))
                0: fr.push_back(8'd43);
                1: fr.push_back(8'd45);
                2: fr.push_back(8'd42);
                default: fr.push_back(8'd47);
            endcase
            repeat (lb) fr.push_back(8'(48 + $urandom_range(0, 9)));
            if ($urandom_range(0, 7) == 0) begin
                pos = $urandom_range(0, fr.size());
                fr.insert(pos, ($urandom_range(0, 1) == 0) ? 8'd120 : 8'd43);
            end
            if ($urandom_range(0, 9) == 0) fr.delete();
            send(8'h00, $urandom_range(0, 3));
            foreach (fr[i]) send(fr[i], $urandom_range(0, 3));
        end
        send(8'h00, 0);
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
